// File: rtl/dm_be_resp_pkg.sv
// rtl/dm_be_resp_pkg.sv - shared FSM encoding, byte-enable codes and lane helpers
package dm_be_resp_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] BE_WORD  = 4'b1111;
  localparam logic [3:0] BE_HALF0 = 4'b0011;
  localparam logic [3:0] BE_HALF1 = 4'b1100;
  localparam logic [3:0] BE_BYTE0 = 4'b0001;
  localparam logic [3:0] BE_BYTE1 = 4'b0010;
  localparam logic [3:0] BE_BYTE2 = 4'b0100;
  localparam logic [3:0] BE_BYTE3 = 4'b1000;

  function automatic logic be_legal(input logic [3:0] be);
    case (be)
      BE_WORD, BE_HALF0, BE_HALF1,
      BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3: be_legal = 1'b1;
      default:                                be_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    be_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Right-aligned store data replicated so every candidate lane sees it.
  function automatic logic [31:0] be_repl(input logic [3:0] be, input logic [31:0] wdata);
    case (be)
      BE_WORD:            be_repl = wdata;
      BE_HALF0, BE_HALF1: be_repl = {2{wdata[15:0]}};
      default:            be_repl = {4{wdata[7:0]}};
    endcase
  endfunction

endpackage

// File: rtl/dm_be_resp_if.sv
// rtl/dm_be_resp_if.sv - request/response bus between MEM stage and responder
interface dm_be_resp_if #(
  parameter int ADDR_W = 10
);
  logic              Req;
  logic              We;
  logic [ADDR_W+1:0] Addr;
  logic [3:0]        Membe;
  logic              Sign;
  logic [31:0]       Wdata;
  logic              Busy;
  logic              Ready;
  logic [31:0]       Rdata;
  logic              Err;

  modport master (
    output Req, We, Addr, Membe, Sign, Wdata,
    input  Busy, Ready, Rdata, Err
  );

  modport slave (
    input  Req, We, Addr, Membe, Sign, Wdata,
    output Busy, Ready, Rdata, Err
  );
endinterface

// File: rtl/dm_be_resp_load_ext.sv
// rtl/dm_be_resp_load_ext.sv - extract enabled lane(s), right-align, sign/zero extend
module dm_be_resp_load_ext
  import dm_be_resp_pkg::*;
(
  input  logic [31:0] word,
  input  logic [3:0]  be,
  input  logic        sign,
  output logic [31:0] result,
  output logic        illegal
);

  always_comb begin
    result  = 32'd0;
    illegal = 1'b0;
    case (be)
      BE_WORD:  result = word;
      BE_BYTE0: result = {{24{sign & word[7]}},  word[7:0]};
      BE_BYTE1: result = {{24{sign & word[15]}}, word[15:8]};
      BE_BYTE2: result = {{24{sign & word[23]}}, word[23:16]};
      BE_BYTE3: result = {{24{sign & word[31]}}, word[31:24]};
      BE_HALF0: result = {{16{sign & word[15]}}, word[15:0]};
      BE_HALF1: result = {{16{sign & word[31]}}, word[31:16]};
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/dm_be_resp.sv
// rtl/dm_be_resp.sv - byte-enable data-memory responder with configurable wait states
module dm_be_resp
  import dm_be_resp_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          Clk,
  input  logic          Rst_n,
  dm_be_resp_if.slave   bus
);

  logic [31:0]       mem [2**ADDR_W];

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic              lat_we, lat_sign;
  logic [ADDR_W-1:0] lat_idx;
  logic [3:0]        lat_be;
  logic [31:0]       lat_wdata;
  logic [31:0]       rdata;

  logic              cur_we, cur_sign;
  logic [ADDR_W-1:0] cur_idx;
  logic [3:0]        cur_be;
  logic [31:0]       cur_wdata;
  logic [31:0]       cur_word;
  logic [31:0]       ext_data;
  logic              ext_illegal;
  logic              commit;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^bus.Addr[1:0];

  // With zero wait states the commit edge is the accept edge, so the live
  // bus fields must be used there instead of the not-yet-latched copies.
  always_comb begin
    cur_we    = lat_we;
    cur_sign  = lat_sign;
    cur_idx   = lat_idx;
    cur_be    = lat_be;
    cur_wdata = lat_wdata;
    if (state == S_IDLE) begin
      cur_we    = bus.We;
      cur_sign  = bus.Sign;
      cur_idx   = bus.Addr[ADDR_W+1:2];
      cur_be    = bus.Membe;
      cur_wdata = bus.Wdata;
    end
  end

  assign cur_word = mem[cur_idx];

  dm_be_resp_load_ext u_load_ext (
    .word    (cur_word),
    .be      (cur_be),
    .sign    (cur_sign),
    .result  (ext_data),
    .illegal (ext_illegal)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE: begin
        if (bus.Req) begin
          if (WAIT_CYCLES == 0) begin
            state_n = S_RESP;
          end else begin
            state_n = S_WAIT;
            cnt_n   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_n = S_RESP;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign commit = (state_n == S_RESP) && (state != S_RESP);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      rdata     <= 32'd0;
      lat_we    <= 1'b0;
      lat_sign  <= 1'b0;
      lat_idx   <= '0;
      lat_be    <= 4'd0;
      lat_wdata <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == S_IDLE && bus.Req) begin
        lat_we    <= bus.We;
        lat_sign  <= bus.Sign;
        lat_idx   <= bus.Addr[ADDR_W+1:2];
        lat_be    <= bus.Membe;
        lat_wdata <= bus.Wdata;
      end
      if (commit && !cur_we) begin
        rdata <= ext_illegal ? 32'd0 : ext_data;
      end
    end
  end

  // RAM is not reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge Clk) begin
    if (Rst_n && commit && cur_we && be_legal(cur_be)) begin
      mem[cur_idx] <= (cur_word & ~be_mask(cur_be)) | (be_repl(cur_be, cur_wdata) & be_mask(cur_be));
    end
  end

  assign bus.Busy  = (state != S_IDLE);
  assign bus.Ready = (state == S_RESP);
  assign bus.Err   = (state == S_RESP) && !be_legal(lat_be);
  assign bus.Rdata = rdata;

endmodule

// File: tb/tb_dm_be_resp.sv
// tb/tb_dm_be_resp.sv - randomized self-checking bench for dm_be_resp (2 and 0 wait states)
module tb_dm_be_resp;

  localparam int ADDR_W = 10;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 Clk = ~Clk;

  dm_be_resp_if #(.ADDR_W(ADDR_W)) bus0 ();
  dm_be_resp_if #(.ADDR_W(ADDR_W)) bus1 ();

  dm_be_resp #(.ADDR_W(ADDR_W), .WAIT_CYCLES(2)) dut0 (.Clk(Clk), .Rst_n(Rst_n), .bus(bus0));
  dm_be_resp #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut1 (.Clk(Clk), .Rst_n(Rst_n), .bus(bus1));

  logic [31:0] model_mem [2][16];
  logic [31:0] last_rd [2];
  logic [3:0]  legal_list [7] = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int wait_of(input int sel);
    return (sel != 0) ? 0 : 2;
  endfunction

  function automatic logic m_legal(input logic [3:0] be);
    foreach (legal_list[i]) if (legal_list[i] == be) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int low_lane(input logic [3:0] be);
    for (int i = 0; i < 4; i++) if (be[i]) return i;
    return 0;
  endfunction

  // Each enabled lane takes the store byte offset from the lowest enabled lane.
  function automatic logic [31:0] m_store(input logic [31:0] old, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] w = old;
    int lo = low_lane(be);
    for (int i = 0; i < 4; i++)
      if (be[i]) w[8*i +: 8] = wd[8*(i-lo) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] word, input logic [3:0] be, input logic sign);
    longint unsigned v, msk;
    int width;
    if (!m_legal(be)) return 32'd0;
    width = 8 * $countones(be);
    msk = (64'd1 << width) - 1;
    v = (64'(word) >> (8 * low_lane(be))) & msk;
    if (sign && v[width-1]) v = v | ~msk;
    return v[31:0];
  endfunction

  function automatic logic rdy(input int sel);
    return (sel != 0) ? bus1.Ready : bus0.Ready;
  endfunction
  function automatic logic busy(input int sel);
    return (sel != 0) ? bus1.Busy : bus0.Busy;
  endfunction
  function automatic logic err(input int sel);
    return (sel != 0) ? bus1.Err : bus0.Err;
  endfunction
  function automatic logic [31:0] rd(input int sel);
    return (sel != 0) ? bus1.Rdata : bus0.Rdata;
  endfunction

  task automatic drive(input int sel, input logic req, input logic we, input logic [3:0] idx,
                       input logic [3:0] be, input logic sign, input logic [31:0] wd);
    logic [ADDR_W+1:0] a;
    a = {6'd0, idx, 2'($urandom_range(0, 3))};
    if (sel != 0) begin
      bus1.Req = req; bus1.We = we; bus1.Addr = a; bus1.Membe = be; bus1.Sign = sign; bus1.Wdata = wd;
    end else begin
      bus0.Req = req; bus0.We = we; bus0.Addr = a; bus0.Membe = be; bus0.Sign = sign; bus0.Wdata = wd;
    end
  endtask

  // Starts just after a rising edge with the DUT idle; returns likewise.
  task automatic do_op(input int sel, input logic we, input logic [3:0] idx,
                       input logic [3:0] be, input logic sign, input logic [31:0] wd);
    int cyc = 0;
    logic got = 1'b0;
    logic lg = m_legal(be);
    drive(sel, 1'b1, we, idx, be, sign, wd);
    @(posedge Clk); #1;
    drive(sel, 1'b0, 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), $urandom);
    if (!we) last_rd[sel] = m_load(model_mem[sel][idx], be, sign);
    else if (lg) model_mem[sel][idx] = m_store(model_mem[sel][idx], be, wd);
    while (cyc < 20 && !got) begin
      @(negedge Clk);
      cyc++;
      got = rdy(sel);
    end
    check("latency", 32'(cyc), 32'(wait_of(sel) + 1));
    check("err", {31'd0, err(sel)}, {31'd0, ~lg});
    check(we ? "rdata_hold" : "rdata", rd(sel), last_rd[sel]);
    @(posedge Clk); #1;
    check("idle_busy", {31'd0, busy(sel)}, 32'd0);
  endtask

  task automatic handshake(input int sel);
    int win = 0, total = 0, w = wait_of(sel), exp_win = 0, exp_total;
    last_rd[sel] = model_mem[sel][0];
    drive(sel, 1'b1, 1'b0, 4'd0, 4'b1111, 1'b0, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); @(negedge Clk);
      if (rdy(sel)) begin
        win++;
        check("hs_rdata", rd(sel), last_rd[sel]);
      end
    end
    drive(sel, 1'b0, 1'b0, 4'd0, 4'b1111, 1'b0, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); @(negedge Clk);
      if (rdy(sel)) total++;
    end
    total += win;
    for (int k = 0; k * (w + 2) + w <= 9; k++) exp_win++;
    exp_total = (10 + w + 1) / (w + 2);
    check("hs_window", 32'(win), 32'(exp_win));
    check("hs_total", 32'(total), 32'(exp_total));
    @(posedge Clk); #1;
  endtask

  initial begin
    int cnt;
    drive(0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 32'd0);
    drive(1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 32'd0);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    repeat (3) @(posedge Clk);
    #1 Rst_n = 1'b1;
    @(negedge Clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_busy", {31'd0, busy(s)}, 32'd0);
      check("rst_ready", {31'd0, rdy(s)}, 32'd0);
      check("rst_err", {31'd0, err(s)}, 32'd0);
      check("rst_rdata", rd(s), 32'd0);
    end
    @(posedge Clk); #1;

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++) do_op(s, 1'b1, 4'(i), 4'b1111, 1'b0, $urandom);

    for (int s = 0; s < 2; s++) begin
      do_op(s, 1'b1, 4'd4, 4'b1111, 1'b0, 32'h89ABCDEF);
      do_op(s, 1'b0, 4'd4, 4'b1111, 1'b0, 32'd0);
      check("word_load", rd(s), 32'h89ABCDEF);
      do_op(s, 1'b1, 4'd5, 4'b1111, 1'b0, 32'h80FF7F01);
      do_op(s, 1'b0, 4'd5, 4'b1000, 1'b1, 32'd0);
      check("b3_sext", rd(s), 32'hFFFFFF80);
      do_op(s, 1'b0, 4'd5, 4'b1000, 1'b0, 32'd0);
      check("b3_zext", rd(s), 32'h00000080);
      do_op(s, 1'b0, 4'd5, 4'b0001, 1'b1, 32'd0);
      check("b0_sext", rd(s), 32'h00000001);
      do_op(s, 1'b1, 4'd6, 4'b1111, 1'b0, 32'h11223344);
      do_op(s, 1'b1, 4'd6, 4'b1100, 1'b0, 32'h0000ABCD);
      do_op(s, 1'b0, 4'd6, 4'b1111, 1'b0, 32'd0);
      check("half_merge", rd(s), 32'hABCD3344);
      do_op(s, 1'b0, 4'd6, 4'b1100, 1'b1, 32'd0);
      check("h1_sext", rd(s), 32'hFFFFABCD);
      do_op(s, 1'b1, 4'd6, 4'b0101, 1'b0, 32'hDEADBEEF);
      do_op(s, 1'b0, 4'd6, 4'b0000, 1'b0, 32'd0);
      check("illegal_rd", rd(s), 32'd0);
      do_op(s, 1'b0, 4'd6, 4'b1111, 1'b0, 32'd0);
      check("illegal_nowr", rd(s), 32'hABCD3344);
    end

    for (int n = 0; n < 300; n++) begin
      logic [3:0] be;
      be = ($urandom_range(0, 9) < 7) ? legal_list[$urandom_range(0, 6)] : 4'($urandom);
      do_op($urandom_range(0, 1), 1'($urandom), 4'($urandom), be, 1'($urandom), $urandom);
    end

    handshake(0);
    handshake(1);

    drive(0, 1'b1, 1'b1, 4'd8, 4'b1111, 1'b0, ~model_mem[0][8]);
    @(posedge Clk); #1;
    drive(0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 32'd0);
    @(negedge Clk);
    check("mid_busy", {31'd0, bus0.Busy}, 32'd1);
    Rst_n = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    check("abort_busy", {31'd0, bus0.Busy}, 32'd0);
    check("abort_rdata", bus0.Rdata, 32'd0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (bus0.Ready) cnt++;
    end
    check("abort_noready", 32'(cnt), 32'd0);
    @(posedge Clk); #1;
    do_op(0, 1'b0, 4'd8, 4'b1111, 1'b0, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
